// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter: source IDs, transfer size
// encodings and the lock state encoding used by the grant logic.
package sram_like_arbiter_pkg;

  typedef logic src_id_t;

  localparam src_id_t SRC_INST = 1'b0;
  localparam src_id_t SRC_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_state_e;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of 1-bit source IDs. Remembers which requester issued each
// accepted transaction so returning responses can be steered back to it.
module sram_like_id_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             din_i,
  output logic             dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    else                        return p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointer and occupancy; simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO and discards any in-flight IDs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the instruction-fetch and data sram-like channels onto one sram-like
// master port. Grants are held (locked) until the bridge accepts, and an
// in-order ID FIFO steers each response back to the requester that issued it.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants when both sources
// request and no lock is held; otherwise data has fixed priority over inst.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic [31:0]      inst_rdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic [31:0]      data_rdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  output logic [CNT_W-1:0] outstanding,
  output logic             proto_err
);

  lock_state_e      lock_q, lock_d;
  logic             proto_err_q, proto_err_d;
  logic             gnt_vld;
  src_id_t          gnt_src;
  logic             accept;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic             fifo_head;
  logic [CNT_W-1:0] fifo_count;

`ifdef ARB_ROUND_ROBIN_EN
  src_id_t rr_ptr_q, rr_ptr_d;

  // Round-robin pointer moves to the other source on every accept.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = ~rr_ptr_q;
  end

  // Pointer register; starts out favouring data.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= SRC_DATA;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Grant selection. A full FIFO blocks all grants so m_req never depends on
  // m_data_ok; a held lock overrides the other source's request.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_DATA;
    if (!fifo_full) begin
      if (lock_q == LK_INST) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_INST;
      end else if (lock_q == LK_DATA) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_DATA;
`ifdef ARB_ROUND_ROBIN_EN
      end else if (data_req && inst_req) begin
        gnt_vld = 1'b1;
        gnt_src = rr_ptr_q;
`endif
      end else if (data_req) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_DATA;
      end else if (inst_req) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_INST;
      end
    end
  end

  // Master port mux; fields read zero when nothing is granted.
  always_comb begin
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (gnt_vld) begin
      if (gnt_src == SRC_DATA) begin
        m_req   = data_req;
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_req   = inst_req;
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_addr  = inst_addr;
        m_wdata = inst_wdata;
      end
    end
  end

  assign accept       = m_req & m_addr_ok;
  assign inst_addr_ok = accept & (gnt_src == SRC_INST);
  assign data_addr_ok = accept & (gnt_src == SRC_DATA);

  // Responses return in acceptance order, so the FIFO head names the owner.
  assign fifo_pop     = m_data_ok & ~fifo_empty;
  assign inst_data_ok = fifo_pop & (fifo_head == SRC_INST);
  assign data_data_ok = fifo_pop & (fifo_head == SRC_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign outstanding  = fifo_count;
  assign proto_err    = proto_err_q;

  // Lock next state and sticky protocol error.
  always_comb begin
    lock_d      = lock_q;
    proto_err_d = proto_err_q | (m_data_ok & fifo_empty);
    if (accept) begin
      lock_d = LK_NONE;
    end else if (m_req) begin
      lock_d = (gnt_src == SRC_DATA) ? LK_DATA : LK_INST;
    end
  end

  // Lock and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q      <= LK_NONE;
      proto_err_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      proto_err_q <= proto_err_d;
    end
  end

  sram_like_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .pop_i   (fifo_pop),
    .din_i   (gnt_src),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model of the arbitration and routing rules.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int MAXO  = 2;
  localparam int CNT_W = $clog2(MAXO + 1);
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size, m_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata, m_rdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic m_req, m_wr, m_addr_ok, m_data_ok, proto_err;
  logic [CNT_W-1:0] outstanding;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .outstanding(outstanding), .proto_err(proto_err)
  );

  // ---------------- reference model ----------------
  // Owners of accepted, unanswered transactions, oldest first.
  src_id_t mq[$];
  bit      mproto;
  bit      mlock_vld;
  src_id_t mlock_src;
  src_id_t mrr;

  typedef struct {
    bit          vld;
    src_id_t     src;
    bit          req;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          iaok, daok, idok, ddok;
    int          out;
    bit          proto;
  } exp_t;

  function automatic exp_t model_outputs();
    exp_t e;
    e.vld = 1'b0; e.src = SRC_DATA;
    if (mq.size() < MAXO) begin
      if (mlock_vld)                 begin e.vld = 1'b1; e.src = mlock_src; end
      else if (inst_req && data_req) begin e.vld = 1'b1; e.src = RR ? mrr : SRC_DATA; end
      else if (data_req)             begin e.vld = 1'b1; e.src = SRC_DATA; end
      else if (inst_req)             begin e.vld = 1'b1; e.src = SRC_INST; end
    end
    e.req = 1'b0; e.wr = 1'b0; e.size = 2'd0; e.addr = 32'd0; e.wdata = 32'd0;
    if (e.vld && e.src == SRC_DATA) begin
      e.req = data_req; e.wr = data_wr; e.size = data_size; e.addr = data_addr; e.wdata = data_wdata;
    end else if (e.vld) begin
      e.req = inst_req; e.wr = inst_wr; e.size = inst_size; e.addr = inst_addr; e.wdata = inst_wdata;
    end
    e.iaok  = e.req && m_addr_ok && (e.src == SRC_INST);
    e.daok  = e.req && m_addr_ok && (e.src == SRC_DATA);
    e.idok  = m_data_ok && (mq.size() > 0) && (mq[0] == SRC_INST);
    e.ddok  = m_data_ok && (mq.size() > 0) && (mq[0] == SRC_DATA);
    e.out   = mq.size();
    e.proto = mproto;
    return e;
  endfunction

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    exp_t e;
    e = model_outputs();
    if (reset) begin
      mq.delete(); mproto = 1'b0; mlock_vld = 1'b0; mlock_src = SRC_DATA; mrr = SRC_DATA;
    end else begin
      if (m_data_ok) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else               mproto = 1'b1;
      end
      if (e.req && m_addr_ok) begin
        mq.push_back(e.src); mlock_vld = 1'b0; mrr = ~mrr;
      end else if (e.req) begin
        mlock_vld = 1'b1; mlock_src = e.src;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = SZ_WORD; data_addr = 0; data_wdata = 0;
    m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                       input bit aok, input bit dok, input logic [31:0] rd);
    @(negedge clk);
    inst_req = ir; inst_addr = ia; data_req = dr; data_addr = da;
    m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      bad++; $display("FAIL reset_hs got=%05b exp=00000",
                      {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    total++;
    if ({outstanding, proto_err} !== {2'd0, 1'b0}) begin
      bad++; $display("FAIL reset_state got out=%0d err=%0b exp out=0 err=0", outstanding, proto_err);
    end
  endtask

  task automatic test_single_inst();
    logic [4:0]  hs_exp [5] = '{5'b10000, 5'b11000, 5'b00000, 5'b00010, 5'b00000};
    logic [1:0]  out_exp[5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(1, 32'hBFC00000, 0, 0, 0, 0, 0);
        1: drive(1, 32'hBFC00000, 0, 0, 1, 0, 0);
        3: drive(0, 0, 0, 0, 0, 1, 32'h3C1D0000);
        default: drive(0, 0, 0, 0, 0, 0, 0);
      endcase
      total++;
      if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== hs_exp[c]) begin
        bad++; $display("FAIL single_hs c%0d got=%05b exp=%05b", c,
                        {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, hs_exp[c]);
      end
      total++;
      if (outstanding !== out_exp[c]) begin
        bad++; $display("FAIL single_out c%0d got=%0d exp=%0d", c, outstanding, out_exp[c]);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    data_wr = 1; data_wdata = 32'h12345678;
    drive(1, 32'hBFC00004, 1, 32'h800D0000, 1, 0, 0);
    total++;
    if ({m_req, inst_addr_ok, data_addr_ok, m_wr, m_addr, m_wdata} !== {4'b1011, 32'h800D0000, 32'h12345678}) begin
      bad++; $display("FAIL prio_data_first got req=%0b iaok=%0b daok=%0b wr=%0b addr=%h wdata=%h exp 1 0 1 1 800d0000 12345678",
                      m_req, inst_addr_ok, data_addr_ok, m_wr, m_addr, m_wdata);
    end
    drive(1, 32'hBFC00004, 0, 0, 1, 0, 0);
    total++;
    if ({m_req, inst_addr_ok, data_addr_ok, m_wr, m_addr, outstanding} !== {4'b1100, 32'hBFC00004, 2'd1}) begin
      bad++; $display("FAIL prio_inst_second got req=%0b iaok=%0b daok=%0b wr=%0b addr=%h out=%0d exp 1 1 0 0 bfc00004 1",
                      m_req, inst_addr_ok, data_addr_ok, m_wr, m_addr, outstanding);
    end
    drive(0, 0, 0, 0, 0, 1, 32'hAAAA0001);
    total++;
    if ({inst_data_ok, data_data_ok, data_rdata, outstanding} !== {2'b01, 32'hAAAA0001, 2'd2}) begin
      bad++; $display("FAIL prio_resp0 got idok=%0b ddok=%0b rdata=%h out=%0d exp 0 1 aaaa0001 2",
                      inst_data_ok, data_data_ok, data_rdata, outstanding);
    end
    drive(0, 0, 0, 0, 0, 1, 32'hBBBB0002);
    total++;
    if ({inst_data_ok, data_data_ok, inst_rdata, outstanding} !== {2'b10, 32'hBBBB0002, 2'd1}) begin
      bad++; $display("FAIL prio_resp1 got idok=%0b ddok=%0b rdata=%h out=%0d exp 1 0 bbbb0002 1",
                      inst_data_ok, data_data_ok, inst_rdata, outstanding);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (outstanding !== 2'd0) begin
      bad++; $display("FAIL prio_drain got=%0d exp=0", outstanding);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, 32'hBFC00010, c > 0, 32'h80001000, c == 3, 0, 0);
      total++;
      if ({m_req, inst_addr_ok, data_addr_ok, m_addr} !== {1'b1, c == 3, 1'b0, 32'hBFC00010}) begin
        bad++; $display("FAIL lock_hold c%0d got req=%0b iaok=%0b daok=%0b addr=%h exp 1 %0b 0 bfc00010",
                        c, m_req, inst_addr_ok, data_addr_ok, m_addr, c == 3);
      end
    end
    drive(0, 0, 1, 32'h80001000, 1, 0, 0);
    total++;
    if ({m_req, inst_addr_ok, data_addr_ok, m_addr} !== {3'b101, 32'h80001000}) begin
      bad++; $display("FAIL lock_release got req=%0b iaok=%0b daok=%0b addr=%h exp 1 0 1 80001000",
                      m_req, inst_addr_ok, data_addr_ok, m_addr);
    end
    drive(0, 0, 0, 0, 0, 1, 32'h11);
    total++;
    if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      bad++; $display("FAIL lock_resp0 got=%02b exp=10", {inst_data_ok, data_data_ok});
    end
    drive(0, 0, 0, 0, 0, 1, 32'h22);
    total++;
    if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      bad++; $display("FAIL lock_resp1 got=%02b exp=01", {inst_data_ok, data_data_ok});
    end
  endtask

  task automatic test_full();
    logic [4:0] hs_exp [10] = '{5'b11000, 5'b11000, 5'b00000, 5'b00000, 5'b00010,
                                5'b11000, 5'b00010, 5'b11010, 5'b00010, 5'b00000};
    logic [1:0] out_exp[10] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: drive(1, 32'hA0, 0, 0, 1, 0, 0);
        1: drive(1, 32'hA4, 0, 0, 1, 0, 0);
        2, 3: drive(1, 32'hA8, 0, 0, 1, 0, 0);
        4: drive(1, 32'hA8, 0, 0, 1, 1, 32'h5);
        5: drive(1, 32'hA8, 0, 0, 1, 0, 0);
        6: drive(0, 0, 0, 0, 0, 1, 32'h6);
        7: drive(1, 32'hAC, 0, 0, 1, 1, 32'h7);
        8: drive(0, 0, 0, 0, 0, 1, 32'h8);
        default: drive(0, 0, 0, 0, 0, 0, 0);
      endcase
      total++;
      if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== hs_exp[c]) begin
        bad++; $display("FAIL full_hs c%0d got=%05b exp=%05b", c,
                        {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, hs_exp[c]);
      end
      total++;
      if (outstanding !== out_exp[c]) begin
        bad++; $display("FAIL full_out c%0d got=%0d exp=%0d", c, outstanding, out_exp[c]);
      end
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0, c == 0, 32'hDEAD);
      total++;
      if ({inst_data_ok, data_data_ok, proto_err} !== {2'b00, c > 0}) begin
        bad++; $display("FAIL proto_c%0d got idok=%0b ddok=%0b err=%0b exp 0 0 %0b",
                        c, inst_data_ok, data_data_ok, proto_err, c > 0);
      end
    end
    do_reset();
    #1;
    total++;
    if (proto_err !== 1'b0) begin
      bad++; $display("FAIL proto_clear got=%0b exp=0", proto_err);
    end
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1, 32'hBFC00100, 1, 32'h80002000, 1, c > 0, c);
      total++;
      if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
          ((c % 2 == 0) ? {3'b101, c > 0, 1'b0} : 5'b11001)) begin
        bad++; $display("FAIL rr_hs c%0d got=%05b exp=%05b", c,
                        {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                        (c % 2 == 0) ? {3'b101, c > 0, 1'b0} : 5'b11001);
      end
      total++;
      if (m_addr !== ((c % 2 == 0) ? 32'h80002000 : 32'hBFC00100)) begin
        bad++; $display("FAIL rr_addr c%0d got=%h", c, m_addr);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit ipend = 0, dpend = 0;
    exp_t e;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (!ipend && $urandom_range(0, 2) != 0) begin
        ipend = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
        inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wdata = $urandom;
      end
      inst_req  = ipend;
      data_req  = dpend;
      m_addr_ok = ($urandom_range(0, 3) != 0);
      m_data_ok = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rdata   = $urandom;
      #1;
      e = model_outputs();
      total++;
      if ({m_req, m_wr, m_size} !== {e.req, e.wr, e.size}) begin
        bad++; $display("FAIL rnd_ctrl n%0d got req/wr/size=%0b/%0b/%0d exp=%0b/%0b/%0d",
                        n, m_req, m_wr, m_size, e.req, e.wr, e.size);
      end
      total++;
      if ({m_addr, m_wdata} !== {e.addr, e.wdata}) begin
        bad++; $display("FAIL rnd_fields n%0d got addr=%h wdata=%h exp addr=%h wdata=%h",
                        n, m_addr, m_wdata, e.addr, e.wdata);
      end
      total++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {e.iaok, e.daok, e.idok, e.ddok}) begin
        bad++; $display("FAIL rnd_hs n%0d got=%04b exp=%04b", n,
                        {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                        {e.iaok, e.daok, e.idok, e.ddok});
      end
      total++;
      if ({inst_rdata, data_rdata} !== {m_rdata, m_rdata}) begin
        bad++; $display("FAIL rnd_rdata n%0d got=%h/%h exp=%h", n, inst_rdata, data_rdata, m_rdata);
      end
      total++;
      if ({outstanding, proto_err} !== {CNT_W'(e.out), e.proto}) begin
        bad++; $display("FAIL rnd_state n%0d got out=%0d err=%0b exp out=%0d err=%0b",
                        n, outstanding, proto_err, e.out, e.proto);
      end
      if (e.iaok) ipend = 0;
      if (e.daok) dpend = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_inst();
    test_priority();
    test_lock();
    test_full();
    test_proto_err();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
